tnoc_vc_output_scheduler: RTL and testbench



---
 rtl/tnoc_vc_output_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tnoc_vc_output_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tnoc_vc_output_scheduler.sv
// tnoc_vc_output_scheduler
//   Shares one output link among CHANNELS per-VC flit FIFOs. Round-robin
//   arbitration at packet granularity: the winning VC keeps the link from
//   its head flit through its tail flit (wormhole lock). New packets start
//   only on VCs the downstream reports as available.
//
// Optional feature macro: TNOC_VC_SCHED_STATS_EN
//   Adds o_flit_count, a saturating per-VC transfer counter.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   i_clear          synchronous soft clear (same effect as rst on state)
//   i_vc_valid       per-VC FIFO not empty
//   i_vc_head/tail   head/tail markers of each VC's front flit
//   i_vc_flit        front flit per VC, VC i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   o_vc_pop         one-hot pop to the FIFOs on an accepted transfer
//   i_vc_available   downstream VC can take a new packet
//   o_out_valid/i_out_ready/o_out_vc/o_out_flit  output link
//   o_busy           packet lock held
//   o_error          sticky protocol error
//   o_flit_count     per-VC counters (stats build only)
module tnoc_vc_output_scheduler #(
  parameter int CHANNELS    = 2,
  parameter int FLIT_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear,
  input  logic [CHANNELS-1:0]            i_vc_valid,
  input  logic [CHANNELS-1:0]            i_vc_head,
  input  logic [CHANNELS-1:0]            i_vc_tail,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] i_vc_flit,
  output logic [CHANNELS-1:0]            o_vc_pop,
  input  logic [CHANNELS-1:0]            i_vc_available,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [CHANNELS-1:0]            o_out_vc,
  output logic [FLIT_WIDTH-1:0]          o_out_flit,
  output logic                           o_busy,
`ifdef TNOC_VC_SCHED_STATS_EN
  output logic [CHANNELS*COUNT_WIDTH-1:0] o_flit_count,
`endif
  output logic                           o_error
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                               state_q;
  logic [CHANNELS-1:0]                  lock_vc_q;
  logic [PTR_W-1:0]                     rr_ptr_q;
  logic                                 error_q, error_d;

  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  vc_flit;
  logic [CHANNELS-1:0]                  cand;
  logic [CHANNELS-1:0]                  grant_oh;
  logic [PTR_W-1:0]                     grant_idx;
  logic                                 grant_any;
  logic                                 valid_raw;
  logic [CHANNELS-1:0]                  sel_vc;
  logic                                 xfer;
  logic                                 xfer_tail;

  assign vc_flit = i_vc_flit;
  assign cand    = i_vc_valid & i_vc_head & i_vc_available;

  // Rotating search starting just after the last granted VC, so the VC
  // that just finished a packet has lowest priority.
  always_comb begin
    int idx;
    grant_oh  = '0;
    grant_idx = rr_ptr_q;
    grant_any = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(rr_ptr_q) + k) % CHANNELS;
      if (!grant_any && cand[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = PTR_W'(idx);
      end
    end
  end

  // While locked only the owning VC may drive the link.
  assign valid_raw = (state_q == ST_BUSY) ? |(lock_vc_q & i_vc_valid) : grant_any;
  assign sel_vc    = (state_q == ST_BUSY) ? lock_vc_q : grant_oh;

  assign o_out_valid = valid_raw & ~rst;
  assign o_out_vc    = o_out_valid ? sel_vc : '0;
  assign xfer        = o_out_valid & i_out_ready;
  assign o_vc_pop    = xfer ? o_out_vc : '0;
  assign xfer_tail   = |(o_out_vc & i_vc_tail);

  always_comb begin
    o_out_flit = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (o_out_vc[i]) o_out_flit = o_out_flit | vc_flit[i];
  end

  // Body flit at the front of any FIFO while idle, or a second head inside
  // the locked packet, both mean the upstream framing is broken.
  always_comb begin
    error_d = error_q;
    if (state_q == ST_IDLE && |(i_vc_valid & ~i_vc_head))
      error_d = 1'b1;
    if (state_q == ST_BUSY && |(lock_vc_q & i_vc_valid & i_vc_head))
      error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      state_q   <= ST_IDLE;
      lock_vc_q <= '0;
      rr_ptr_q  <= PTR_W'(CHANNELS-1);
      error_q   <= 1'b0;
    end else begin
      error_q <= error_d;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            rr_ptr_q <= grant_idx;
            if (!xfer_tail) begin
              state_q   <= ST_BUSY;
              lock_vc_q <= grant_oh;
            end
          end
        end
        ST_BUSY: begin
          if (xfer && xfer_tail) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (state_q == ST_BUSY);
  assign o_error = error_q;

`ifdef TNOC_VC_SCHED_STATS_EN
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CHANNELS; i++)
      if (o_vc_pop[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign o_flit_count = cnt_q;
`endif

endmodule

// File: tb/tb_tnoc_vc_output_scheduler.sv
module tb_tnoc_vc_output_scheduler;

  localparam int CH = 2;
  localparam int FW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, i_clear;
  logic [CH-1:0] i_vc_valid, i_vc_head, i_vc_tail, i_vc_available;
  logic [FW-1:0] flit0, flit1;
  logic [CH*FW-1:0] i_vc_flit;
  logic [CH-1:0] o_vc_pop, o_out_vc;
  logic          o_out_valid, i_out_ready, o_busy, o_error;
  logic [FW-1:0] o_out_flit;
`ifdef TNOC_VC_SCHED_STATS_EN
  logic [CH*CW-1:0] o_flit_count;
`endif

  int total = 0;
  int bad   = 0;

  assign i_vc_flit = {flit1, flit0};

  always #5 clk = ~clk;

  tnoc_vc_output_scheduler #(.CHANNELS(CH), .FLIT_WIDTH(FW), .COUNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (i_clear),
    .i_vc_valid     (i_vc_valid),
    .i_vc_head      (i_vc_head),
    .i_vc_tail      (i_vc_tail),
    .i_vc_flit      (i_vc_flit),
    .o_vc_pop       (o_vc_pop),
    .i_vc_available (i_vc_available),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_vc       (o_out_vc),
    .o_out_flit     (o_out_flit),
    .o_busy         (o_busy),
`ifdef TNOC_VC_SCHED_STATS_EN
    .o_flit_count   (o_flit_count),
`endif
    .o_error        (o_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are changed and outputs sampled away from the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drive one VC's front-of-FIFO: valid, head, tail, flit
  task automatic vc(input int n, input logic v, input logic h, input logic t, input logic [FW-1:0] f);
    i_vc_valid[n] = v;
    i_vc_head[n]  = h;
    i_vc_tail[n]  = t;
    if (n == 0) flit0 = f; else flit1 = f;
  endtask

  // check link outputs for one cycle
  task automatic link(input string tag, input logic v, input logic [CH-1:0] ovc,
                      input logic [CH-1:0] pop, input logic [FW-1:0] f, input logic busy);
    chk({tag, ".valid"}, 64'(o_out_valid), 64'(v));
    chk({tag, ".vc"},    64'(o_out_vc),    64'(ovc));
    chk({tag, ".pop"},   64'(o_vc_pop),    64'(pop));
    chk({tag, ".flit"},  o_out_flit,       f);
    chk({tag, ".busy"},  64'(o_busy),      64'(busy));
  endtask

  initial begin
    rst = 1'b1; i_clear = 1'b0; i_out_ready = 1'b1;
    i_vc_available = 2'b11;
    vc(0, 1, 1, 1, 64'hA0); vc(1, 1, 1, 1, 64'hB0);

    // reset: link held quiet even with requests present
    tick; #1;
    link("rst", 0, 2'b00, 2'b00, 64'h0, 0);
    chk("rst.err", 64'(o_error), 64'h0);
    tick;
    rst = 1'b0;

    // round robin of single-flit packets, VC0 first after reset
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) link($sformatf("rr%0d", i), 1, 2'b01, 2'b01, 64'hA0, 0);
      else            link($sformatf("rr%0d", i), 1, 2'b10, 2'b10, 64'hB0, 0);
      tick;
    end

    // wormhole: VC1 4-flit packet, VC0 head arrives after VC1 locks
    vc(0, 0, 0, 0, 64'h0); vc(1, 1, 1, 0, 64'hB10);
    #1; link("wh.head", 1, 2'b10, 2'b10, 64'hB10, 0);
    tick;
    vc(0, 1, 1, 1, 64'hA1); vc(1, 1, 0, 0, 64'hB11);
    #1; link("wh.body1", 1, 2'b10, 2'b10, 64'hB11, 1);
    tick;
    vc(1, 1, 0, 0, 64'hB12);
    #1; link("wh.body2", 1, 2'b10, 2'b10, 64'hB12, 1);
    tick;
    // backpressure on the tail for 3 cycles
    vc(1, 1, 0, 1, 64'hB13);
    i_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; link($sformatf("bp%0d", i), 1, 2'b10, 2'b00, 64'hB13, 1);
      tick;
    end
    i_out_ready = 1'b1;
    #1; link("wh.tail", 1, 2'b10, 2'b10, 64'hB13, 1);
    chk("wh.err", 64'(o_error), 64'h0);
    tick;
    vc(1, 0, 0, 0, 64'h0);
    #1; link("wh.vc0", 1, 2'b01, 2'b01, 64'hA1, 0);
    tick;

    // availability gating: VC0 waits while VC1 flows
    i_vc_available = 2'b10;
    vc(0, 1, 1, 1, 64'hA2);
    for (int i = 0; i < 5; i++) begin
      vc(1, 1, 1, 1, 64'hB20 + 64'(i));
      #1; link($sformatf("av%0d", i), 1, 2'b10, 2'b10, 64'hB20 + 64'(i), 0);
      tick;
    end
    i_vc_available = 2'b11;
    vc(1, 1, 1, 1, 64'hB25);
    #1; link("av.rise", 1, 2'b01, 2'b01, 64'hA2, 0);
    tick;

    // nothing requesting: link all zero
    vc(0, 0, 0, 0, 64'h5); vc(1, 0, 0, 0, 64'h6);
    #1; link("idle", 0, 2'b00, 2'b00, 64'h0, 0);
    tick;

    // body flit in IDLE: flagged, never granted
    vc(0, 1, 0, 0, 64'hA3);
    #1; link("perr", 0, 2'b00, 2'b00, 64'h0, 0);
    chk("perr.pre", 64'(o_error), 64'h0);
    tick;
    chk("perr.set", 64'(o_error), 64'h1);

    // clear mid-packet; rr_ptr last at VC0 so VC1 wins the head
    vc(0, 0, 0, 0, 64'h0); vc(1, 1, 1, 0, 64'hB30);
    #1; link("clr.head", 1, 2'b10, 2'b10, 64'hB30, 0);
    tick;
    chk("clr.err_hold", 64'(o_error), 64'h1);
    vc(1, 1, 0, 0, 64'hB31);
    i_clear = 1'b1;
    #1; link("clr.pop", 1, 2'b10, 2'b10, 64'hB31, 1);
    tick;
    i_clear = 1'b0;
    chk("clr.busy", 64'(o_busy), 64'h0);
    chk("clr.err", 64'(o_error), 64'h0);
    // rr_ptr back to CHANNELS-1: VC0 wins a tie
    vc(0, 1, 1, 1, 64'hA4); vc(1, 1, 1, 1, 64'hB4);
    #1; link("clr.rr", 1, 2'b01, 2'b01, 64'hA4, 0);
    tick;

`ifdef TNOC_VC_SCHED_STATS_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vc(0, 1, 1, 1, 64'hC0); vc(1, 0, 0, 0, 64'h0);
    #1; chk("st.zero", 64'(o_flit_count), 64'h0);
    for (int i = 0; i < 20; i++) tick;
    chk("st.cnt0", 64'(o_flit_count[CW-1:0]), 64'd15);
    chk("st.cnt1", 64'(o_flit_count[2*CW-1:CW]), 64'd0);
    i_clear = 1'b1;
    tick;
    i_clear = 1'b0;
    vc(0, 0, 0, 0, 64'h0);
    chk("st.clr", 64'(o_flit_count), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
